imem_loader: RTL

Boot-time writer for the core's instruction memory. It accepts a framed byte stream from a UART receiver (valid/ready), packs little-endian bytes into 32-bit words, and drives a word write port into IMEM. It also holds the CPU in reset until a complete frame with a valid checksum has been written. It sits between the board UART RX and the IMEM write port, alongside the core's combinational instruction fetch.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_if.sv | 9 +
 rtl/imem_loader_word_packer.sv | 29 ++
 rtl/imem_loader.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // One extra bit so that a frame filling the whole memory is representable.
    function automatic int idx_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream handshake from the UART receiver into the loader.
interface imem_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; first byte lands in [7:0].
module word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_stb_i,
    input  logic [7:0]  byte_i,
    input  logic        clear_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [23:0] sr_q;
    logic [1:0]  lane_q;

    // The fourth byte completes the word directly, so the word is usable in its handshake cycle.
    assign word_valid_o = byte_stb_i && (lane_q == 2'd3);
    assign word_o       = {byte_i, sr_q};

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            sr_q   <= '0;
            lane_q <= '0;
        end else if (byte_stb_i) begin
            sr_q   <= {byte_i, sr_q[23:8]};
            lane_q <= lane_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed UART bytes -> IMEM word writes, holds the CPU in reset until a good frame.
//   state  | meaning
//   S_SYNC | hunting for the sync byte
//   S_LEN0 | expecting word count low byte
//   S_LEN1 | expecting word count high byte
//   S_DATA | receiving payload bytes
//   S_CSUM | expecting checksum byte
//   S_DONE | frame loaded, CPU released
//   S_ERR  | overflow or bad checksum
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         DEPTH_WORDS    = 1024,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave rx,
    output logic         imem_we,
    output logic [31:0]  imem_waddr,
    output logic [31:0]  imem_wdata,
    output logic         cpu_rst_n,
    output logic         load_done,
    output logic         load_err
);

    localparam int            IW       = idx_width(DEPTH_WORDS);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [7:0]    len_lo_q, len_lo_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] tmr_q;
    logic          rx_ready_q, imem_we_q, cpu_rst_n_q, load_done_q, load_err_q;
    logic [31:0]   waddr_q, wdata_q;

    logic          accept, in_frame, sync_hit, byte_stb, word_valid, timeout;
    logic [31:0]   word;

    assign accept   = rx.rx_valid && rx_ready_q;
    assign in_frame = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
    assign sync_hit = accept && (state_q == S_SYNC) && (rx.rx_data == SYNC_BYTE);
    assign byte_stb = accept && (state_q == S_DATA);
    // Down-counter is reloaded on every byte; terminal count is one idle cycle short of the limit.
    assign timeout  = in_frame && !accept && (tmr_q == TW'(1));

    word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_stb_i   (byte_stb),
        .byte_i       (rx.rx_data),
        .clear_i      (sync_hit),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        sum_d    = sum_q;
        idx_d    = idx_q;
        case (state_q)
            S_SYNC: if (sync_hit) begin
                state_d = S_LEN0;
                sum_d   = '0;
                idx_d   = '0;
            end
            S_LEN0: if (accept) begin
                len_lo_d = rx.rx_data;
                state_d  = S_LEN1;
            end
            S_LEN1: if (accept) begin
                len_d = {rx.rx_data, len_lo_q};
                if (32'({rx.rx_data, len_lo_q}) > 32'(DEPTH_WORDS)) state_d = S_ERR;
                else if ({rx.rx_data, len_lo_q} == 16'd0)          state_d = S_CSUM;
                else                                               state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                sum_d = sum_q + rx.rx_data;
                if (word_valid) begin
                    idx_d = idx_q + IW'(1);
                    if (32'(idx_q) + 32'd1 == 32'(len_q)) state_d = S_CSUM;
                end
            end
            S_CSUM: if (accept) begin
                state_d = (rx.rx_data == sum_q) ? S_DONE : S_ERR;
            end
            default: ;
        endcase
        if (timeout) state_d = S_SYNC;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_SYNC;
            len_lo_q    <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            tmr_q       <= TMR_LOAD;
            rx_ready_q  <= 1'b0;
            imem_we_q   <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            rx_ready_q  <= !(state_d inside {S_DONE, S_ERR});
            cpu_rst_n_q <= (state_d == S_DONE);
            load_done_q <= (state_d == S_DONE);
            load_err_q  <= (state_d == S_ERR);
            imem_we_q   <= byte_stb && word_valid;
            if (byte_stb && word_valid) begin
                waddr_q <= 32'(idx_q) << 2;
                wdata_q <= word;
            end
            if (accept || !(state_d inside {S_LEN0, S_LEN1, S_DATA, S_CSUM}))
                tmr_q <= TMR_LOAD;
            else
                tmr_q <= tmr_q - TW'(1);
        end
    end

    assign rx.rx_ready = rx_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_waddr  = waddr_q;
    assign imem_wdata  = wdata_q;
    assign cpu_rst_n   = cpu_rst_n_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;

endmodule
